// File: rtl/mem_port_sched.sv
// mem_port_sched: arbitrates one memory port between fetch and load/store with one outstanding transaction,
// flush-driven fetch kill and a bound on fetch starvation behind back-to-back loads/stores.
module mem_port_sched #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [3:0]  ls_be,
  input  logic [4:0]  ls_rd,
  output logic        ls_gnt,
  output logic        ld_valid,
  output logic [4:0]  ld_rd,
  output logic [31:0] ld_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [1:0] K_IF = 2'd0, K_LD = 2'd1, K_ST = 2'd2;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, state_nxt;
  logic [1:0] kind;
  logic [31:0] addr, wdata;
  logic we, kill, idle, if_win, ls_win, grant;
  logic [3:0] be;
  logic [4:0] rd;
  logic [SW-1:0] streak;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  // Grant decision sees only request/flush inputs and held state, never mem_* inputs.
  always_comb begin
    idle = state == IDLE;
    if_win = if_req & ~flush & (~(ls_req & ~flush) | streak == SW'(STARVE_LIMIT));
    ls_win = ls_req & ~flush & ~if_win;
    grant = idle & (if_win | ls_win);
    state_nxt = idle ? (grant ? REQ : IDLE)
              : state == REQ ? (mem_ready ? WAIT : REQ)
              : state == WAIT ? (mem_rvalid ? IDLE : WAIT) : IDLE;
  end
  always_comb begin
    if_gnt = idle & if_win & ~reset;
    ls_gnt = idle & ls_win & ~reset;
    mem_req = state == REQ;
    mem_we = we;
    mem_addr = addr;
    mem_wdata = wdata;
    mem_be = be;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      kind <= K_IF;
      addr <= '0;
      wdata <= '0;
      we <= 1'b0;
      be <= '0;
      rd <= '0;
      streak <= '0;
      kill <= 1'b0;
      if_rvalid <= 1'b0;
      if_rdata <= '0;
      ld_valid <= 1'b0;
      ld_rd <= '0;
      ld_data <= '0;
    end else begin
      if_rvalid <= 1'b0;
      ld_valid <= 1'b0;
      if (grant) begin
        kind <= if_win ? K_IF : (ls_we ? K_ST : K_LD);
        addr <= if_win ? if_addr : ls_addr;
        wdata <= if_win ? '0 : ls_wdata;
        we <= ls_win & ls_we;
        be <= (ls_win & ls_we) ? ls_be : 4'hF;
        streak <= if_win ? '0 : (if_req && streak != SW'(STARVE_LIMIT)) ? streak + SW'(1) : streak;
        if (ls_win) rd <= ls_rd;
      end
      kill <= idle ? 1'b0 : kill | (flush & kind == K_IF);
      if (state == WAIT && mem_rvalid) begin
        if (kind == K_IF && !(kill | flush)) begin
          if_rvalid <= 1'b1;
          if_rdata <= mem_rdata;
        end
        if (kind == K_LD) begin
          ld_valid <= 1'b1;
          ld_rd <= rd;
          ld_data <= mem_rdata;
        end
      end
    end
endmodule

// File: tb/tb_mem_port_sched.sv
// tb_mem_port_sched: directed and random checks of mem_port_sched against a transaction-level reference model.
module tb_mem_port_sched;
  localparam int LIM = 4;
  logic clk = 1'b0;
  logic reset, flush, if_req, ls_req, ls_we, mem_ready, mem_rvalid;
  logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
  logic [3:0] ls_be;
  logic [4:0] ls_rd;
  logic if_gnt, if_rvalid, ls_gnt, ld_valid, mem_req, mem_we;
  logic [31:0] if_rdata, ld_data, mem_addr, mem_wdata;
  logic [4:0] ld_rd;
  logic [3:0] mem_be;
  int n_cmp = 0, n_err = 0;
  bit busy, on_bus, cancelled, m_we, e_ifv, e_ldv;
  int kind, starve;
  logic [31:0] m_addr, m_wdata, e_ifd, e_ldd;
  logic [3:0] m_be;
  logic [4:0] m_rd, e_ldrd;
  bit gq[$];
  logic [5:0] seq;

  mem_port_sched #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be), .ls_rd(ls_rd),
    .ls_gnt(ls_gnt), .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    busy = 0; on_bus = 0; cancelled = 0; m_we = 0; e_ifv = 0; e_ldv = 0;
    kind = 0; starve = 0;
    m_addr = 0; m_wdata = 0; m_be = 0; m_rd = 0; e_ifd = 0; e_ldd = 0; e_ldrd = 0;
  endtask

  task automatic clear_in();
    flush = 0; if_req = 0; ls_req = 0; ls_we = 0; mem_ready = 0; mem_rvalid = 0;
    if_addr = 0; ls_addr = 0; ls_wdata = 0; mem_rdata = 0; ls_be = 0; ls_rd = 0;
  endtask

  task automatic rnd_data();
    if_addr = $urandom; ls_addr = $urandom; ls_wdata = $urandom; mem_rdata = $urandom;
    ls_be = 4'($urandom); ls_rd = 5'($urandom);
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_if_gnt"}, if_gnt, 0);
    chk({tag, "_ls_gnt"}, ls_gnt, 0);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_mem_be"}, mem_be, 0);
    chk({tag, "_if_rvalid"}, if_rvalid, 0);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_ld_valid"}, ld_valid, 0);
    chk({tag, "_ld_rd"}, ld_rd, 0);
    chk({tag, "_ld_data"}, ld_data, 0);
  endtask

  task automatic do_reset();
    reset = 1;
    clear_in();
    @(negedge clk);
    check_zero("rst");
    reset = 0;
    model_reset();
    gq.delete();
  endtask

  // One clock: check outputs against the model, advance the model by the spec rules, cross the edge.
  task automatic tick();
    bit ifok, lsok, gi, gl;
    #1;
    ifok = if_req && !flush;
    lsok = ls_req && !flush;
    gi = !busy && ifok && (!lsok || starve == LIM);
    gl = !busy && lsok && !gi;
    chk("if_gnt", if_gnt, gi);
    chk("ls_gnt", ls_gnt, gl);
    chk("mem_req", mem_req, busy && on_bus);
    chk("mem_we", mem_we, m_we);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("mem_be", mem_be, m_be);
    chk("if_rvalid", if_rvalid, e_ifv);
    chk("if_rdata", if_rdata, e_ifd);
    chk("ld_valid", ld_valid, e_ldv);
    chk("ld_rd", ld_rd, e_ldrd);
    chk("ld_data", ld_data, e_ldd);
    e_ifv = 0;
    e_ldv = 0;
    if (busy) begin
      if (flush && kind == 0) cancelled = 1;
      if (on_bus) begin
        if (mem_ready) on_bus = 0;
      end else if (mem_rvalid) begin
        busy = 0;
        if (kind == 0 && !cancelled) begin e_ifv = 1; e_ifd = mem_rdata; end
        if (kind == 1) begin e_ldv = 1; e_ldrd = m_rd; e_ldd = mem_rdata; end
        cancelled = 0;
      end
    end else if (gi || gl) begin
      gq.push_back(gi);
      busy = 1;
      on_bus = 1;
      kind = gi ? 0 : (ls_we ? 2 : 1);
      m_addr = gi ? if_addr : ls_addr;
      m_we = gl && ls_we;
      m_wdata = gi ? 32'h0 : ls_wdata;
      m_be = (gl && ls_we) ? ls_be : 4'hF;
      if (gl) m_rd = ls_rd;
      starve = gi ? 0 : (if_req && starve < LIM) ? starve + 1 : starve;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(bit ir, bit lr, bit w, bit fl, bit rdy, bit rv);
    if_req = ir; ls_req = lr; ls_we = w; flush = fl; mem_ready = rdy; mem_rvalid = rv;
    tick();
  endtask

  initial begin
    do_reset();
    // IF only, rdata arrives two cycles after acceptance
    if_addr = 32'h100; mem_rdata = 32'hDEADBEEF;
    drive(1, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    #1;
    chk("t1_if_rvalid", if_rvalid, 1);
    chk("t1_if_rdata", if_rdata, 32'hDEADBEEF);
    drive(0, 0, 0, 0, 0, 0);
    // simultaneous load and fetch: load first, fetch on next idle
    do_reset();
    rnd_data(); ls_rd = 5;
    drive(1, 1, 0, 0, 1, 1);
    drive(1, 0, 0, 0, 1, 1);
    drive(1, 0, 0, 0, 1, 1);
    drive(1, 0, 0, 0, 1, 1);
    chk("t2_order", {gq[0], gq[1]}, 2'b01);
    chk("t2_ld_rd", ld_rd, 5);
    // starvation bound with if_req held
    do_reset();
    for (int i = 0; i < 18; i++) begin rnd_data(); drive(1, 1, 0, 0, 1, 1); end
    chk("t3_grants", gq.size(), 6);
    seq = 0;
    for (int i = 0; i < 6 && i < gq.size(); i++) seq = {seq[4:0], gq[i]};
    chk("t3_seq", seq, 6'b000010);
    // flush during fetch WAIT, then during load WAIT
    do_reset();
    rnd_data();
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    #1;
    chk("t4_if_killed", if_rvalid, 0);
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 1);
    #1;
    chk("t4_ld_valid", ld_valid, 1);
    drive(0, 0, 0, 0, 0, 0);
    // store with partial byte enables
    rnd_data(); ls_be = 4'b0011;
    drive(0, 1, 1, 0, 0, 0);
    #1;
    chk("t5_mem_we", mem_we, 1);
    chk("t5_mem_be", mem_be, 4'b0011);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0);
    rnd_data();
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    // stalled REQ, then async reset in WAIT
    do_reset();
    rnd_data();
    drive(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin rnd_data(); drive(0, 0, 0, 0, 0, 1); end
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0);
    clear_in();
    reset = 1;
    #1;
    check_zero("t6_async");
    @(negedge clk);
    reset = 0;
    model_reset();
    rnd_data();
    drive(1, 0, 0, 0, 0, 0);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      rnd_data();
      drive(1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0,
            1'($urandom), 1'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
